// File: rtl/queue_controller_param.sv
// queue_controller_param: circular operand queue with head/tail pointers, sticky error flags and a sequenced calc read-read-write
module queue_controller_param #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [1:0]    opcode,
  output logic          op_ready,
  input  logic          err_clr,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  output logic          mem_rd_opb,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          err_overflow,
  output logic          err_underflow
);
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, WB} state_t;
  localparam logic [AW:0] D = (AW+1)'(DEPTH);
  state_t state, state_n;
  logic [AW-1:0] b, w;
  logic acc, push_ok, pop_ok, calc_ok, ovf_set, unf_set;
  function automatic logic [AW-1:0] adv(input logic [AW-1:0] p, input logic [AW:0] n);
    logic [AW:0] s;
    s = {1'b0, p} + n;
    return (s >= D) ? AW'(s - D) : AW'(s);
  endfunction
  assign full = count == D;
  assign empty = count == '0;
  assign op_ready = state == IDLE;
  always_comb begin
    acc = op_valid && state == IDLE;
    push_ok = acc && opcode == 2'b00 && !full;
    pop_ok = acc && opcode == 2'b11 && !empty;
    calc_ok = acc && opcode == 2'b10 && count >= (AW+1)'(2);
    ovf_set = acc && opcode == 2'b00 && full;
    unf_set = acc && ((opcode == 2'b11 && empty) || (opcode == 2'b10 && count < (AW+1)'(2)));
    state_n = state == IDLE ? (calc_ok ? RD_A : IDLE) : state == RD_A ? RD_B : state == RD_B ? WB : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      b <= '0;
      w <= '0;
      mem_wr_en <= 1'b0;
      mem_wr_addr <= '0;
      mem_rd_en <= 1'b0;
      mem_rd_addr <= '0;
      mem_rd_opb <= 1'b0;
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_n;
      mem_wr_en <= push_ok || state == RD_B;
      mem_wr_addr <= push_ok ? tail : state == RD_B ? w : mem_wr_addr;
      mem_rd_en <= pop_ok || calc_ok || state == RD_A;
      mem_rd_addr <= (pop_ok || calc_ok) ? head : state == RD_A ? b : mem_rd_addr;
      mem_rd_opb <= state == RD_A;
      head <= pop_ok ? adv(head, (AW+1)'(1)) : calc_ok ? adv(head, (AW+1)'(2)) : head;
      tail <= (push_ok || calc_ok) ? adv(tail, (AW+1)'(1)) : tail;
      count <= push_ok ? count + 1'b1 : (pop_ok || calc_ok) ? count - 1'b1 : count;
      b <= calc_ok ? adv(head, (AW+1)'(1)) : b;
      w <= calc_ok ? tail : w;
      err_overflow <= ovf_set || (err_overflow && !err_clr);
      err_underflow <= unf_set || (err_underflow && !err_clr);
    end
  end
endmodule

// File: tb/tb_queue_controller_param.sv
// tb_queue_controller_param: directed scenarios plus randomized run against a queue-level reference model
module tb_queue_controller_param;
  localparam int DEPTH = 5;
  localparam int AW = 3;
  logic clk = 1'b0, rst = 1'b1, op_valid = 1'b0, err_clr = 1'b0;
  logic [1:0] opcode = 2'b01;
  logic op_ready, mem_wr_en, mem_rd_en, mem_rd_opb, full, empty, err_overflow, err_underflow;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr, head, tail;
  logic [AW:0] count;
  int nvec = 0, nerr = 0;
  int m_head, m_tail, m_count, m_busy, e_rd_addr, e_wr_addr;
  logic m_ovf, m_unf, e_rd_en, e_rd_opb, e_wr_en;
  int sk[3], sa[3];
  logic so[3];

  queue_controller_param #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode), .op_ready(op_ready),
    .err_clr(err_clr), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_opb(mem_rd_opb), .head(head), .tail(tail), .count(count),
    .full(full), .empty(empty), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Reference: queue occupancy in modular arithmetic plus a schedule of future memory strobes
  task automatic model_edge();
    logic so_, su_;
    so_ = 1'b0;
    su_ = 1'b0;
    if (rst) begin
      m_head = 0; m_tail = 0; m_count = 0; m_busy = 0; m_ovf = 1'b0; m_unf = 1'b0;
      for (int i = 0; i < 3; i++) begin sk[i] = 0; sa[i] = 0; so[i] = 1'b0; end
    end else begin
      if (m_busy > 0) m_busy--;
      else if (op_valid) begin
        case (opcode)
          2'b00: if (m_count == DEPTH) so_ = 1'b1;
                 else begin sk[0] = 2; sa[0] = m_tail; so[0] = 1'b0; m_tail = (m_tail + 1) % DEPTH; m_count++; end
          2'b11: if (m_count == 0) su_ = 1'b1;
                 else begin sk[0] = 1; sa[0] = m_head; so[0] = 1'b0; m_head = (m_head + 1) % DEPTH; m_count--; end
          2'b10: if (m_count < 2) su_ = 1'b1;
                 else begin
                   sk[0] = 1; sa[0] = m_head; so[0] = 1'b0;
                   sk[1] = 1; sa[1] = (m_head + 1) % DEPTH; so[1] = 1'b1;
                   sk[2] = 2; sa[2] = m_tail; so[2] = 1'b0;
                   m_head = (m_head + 2) % DEPTH; m_tail = (m_tail + 1) % DEPTH; m_count--; m_busy = 3;
                 end
          default: ;
        endcase
      end
      m_ovf = so_ | (m_ovf & !err_clr);
      m_unf = su_ | (m_unf & !err_clr);
    end
    e_rd_en = sk[0] == 1; e_rd_opb = so[0]; e_rd_addr = sa[0];
    e_wr_en = sk[0] == 2; e_wr_addr = sa[0];
    sk[0] = sk[1]; sa[0] = sa[1]; so[0] = so[1];
    sk[1] = sk[2]; sa[1] = sa[2]; so[1] = so[2];
    sk[2] = 0; sa[2] = 0; so[2] = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic [1:0] o, input logic c, input logic r);
    op_valid = v; opcode = o; err_clr = c; rst = r;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 2'b00, 1'b0, 1'b1);
    cyc(1'b0, 2'b01, 1'b0, 1'b1);
    nvec++; if ({op_ready, head, tail, count, empty, full} !== {1'b1, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0}) begin nerr++; $display("FAIL reset_state got %b want %b", {op_ready, head, tail, count, empty, full}, {1'b1, 10'd0, 2'b10}); end
    nvec++; if ({mem_wr_en, mem_rd_en, mem_rd_opb, err_overflow, err_underflow} !== 5'd0) begin nerr++; $display("FAIL reset_flags got %b want 00000", {mem_wr_en, mem_rd_en, mem_rd_opb, err_overflow, err_underflow}); end
  endtask

  task automatic test_overflow();
    cyc(1'b0, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'b00, 1'b0, 1'b0);
      nvec++; if ({mem_wr_en, mem_wr_addr} !== {1'b1, 3'(i)}) begin nerr++; $display("FAIL push_strobe[%0d] got en=%b addr=%0d want en=1 addr=%0d", i, mem_wr_en, mem_wr_addr, i); end
    end
    nvec++; if ({count, full} !== {4'd5, 1'b1}) begin nerr++; $display("FAIL fill_count got count=%0d full=%b want 5 1", count, full); end
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    nvec++; if ({err_overflow, mem_wr_en, tail, count} !== {1'b1, 1'b0, 3'd0, 4'd5}) begin nerr++; $display("FAIL overflow got ovf=%b wr=%b tail=%0d count=%0d want 1 0 0 5", err_overflow, mem_wr_en, tail, count); end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 2'b01, 1'b0, 1'b1);
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    nvec++; if ({err_underflow, mem_rd_en} !== 2'b10) begin nerr++; $display("FAIL pop_empty got unf=%b rd=%b want 1 0", err_underflow, mem_rd_en); end
    cyc(1'b0, 2'b01, 1'b1, 1'b0);
    nvec++; if (err_underflow !== 1'b0) begin nerr++; $display("FAIL err_clr got %b want 0", err_underflow); end
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    nvec++; if ({err_underflow, count, op_ready, mem_rd_en} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin nerr++; $display("FAIL calc_short got unf=%b count=%0d rdy=%b rd=%b want 1 1 1 0", err_underflow, count, op_ready, mem_rd_en); end
  endtask

  task automatic test_calc_wrap();
    cyc(1'b0, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b11, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    nvec++; if ({head, tail, count} !== {3'd3, 3'd1, 4'd3}) begin nerr++; $display("FAIL calc_setup got h=%0d t=%0d c=%0d want 3 1 3", head, tail, count); end
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    nvec++; if ({op_ready, mem_rd_en, mem_rd_addr, mem_rd_opb} !== {1'b0, 1'b1, 3'd3, 1'b0}) begin nerr++; $display("FAIL calc_rda got rdy=%b rd=%b a=%0d opb=%b want 0 1 3 0", op_ready, mem_rd_en, mem_rd_addr, mem_rd_opb); end
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    nvec++; if ({op_ready, mem_rd_en, mem_rd_addr, mem_rd_opb} !== {1'b0, 1'b1, 3'd4, 1'b1}) begin nerr++; $display("FAIL calc_rdb got rdy=%b rd=%b a=%0d opb=%b want 0 1 4 1", op_ready, mem_rd_en, mem_rd_addr, mem_rd_opb); end
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    nvec++; if ({op_ready, mem_wr_en, mem_wr_addr, mem_rd_en} !== {1'b0, 1'b1, 3'd1, 1'b0}) begin nerr++; $display("FAIL calc_wb got rdy=%b wr=%b a=%0d rd=%b want 0 1 1 0", op_ready, mem_wr_en, mem_wr_addr, mem_rd_en); end
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    nvec++; if ({op_ready, mem_wr_en, head, count} !== {1'b1, 1'b0, 3'd0, 4'd2}) begin nerr++; $display("FAIL calc_done got rdy=%b wr=%b h=%0d c=%0d want 1 0 0 2", op_ready, mem_wr_en, head, count); end
    for (int i = 0; i < 2; i++) cyc(1'b1, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    nvec++; if ({mem_rd_addr, mem_rd_opb} !== {3'd4, 1'b0}) begin nerr++; $display("FAIL wrap_rda got a=%0d opb=%b want 4 0", mem_rd_addr, mem_rd_opb); end
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    nvec++; if ({mem_rd_en, mem_rd_addr, mem_rd_opb} !== {1'b1, 3'd0, 1'b1}) begin nerr++; $display("FAIL wrap_rdb got rd=%b a=%0d opb=%b want 1 0 1", mem_rd_en, mem_rd_addr, mem_rd_opb); end
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    nvec++; if ({head, tail, count} !== {3'd1, 3'd2, 4'd1}) begin nerr++; $display("FAIL wrap_head got h=%0d t=%0d c=%0d want 1 2 1", head, tail, count); end
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    nvec++; if ({mem_rd_en, mem_rd_addr} !== {1'b1, 3'd1}) begin nerr++; $display("FAIL full_calc_rd got rd=%b a=%0d want 1 1", mem_rd_en, mem_rd_addr); end
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    nvec++; if ({mem_wr_en, mem_wr_addr} !== {1'b1, 3'd1}) begin nerr++; $display("FAIL full_calc_wr got wr=%b a=%0d want 1 1", mem_wr_en, mem_wr_addr); end
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    nvec++; if ({op_ready, count, err_overflow} !== {1'b1, 4'd4, 1'b0}) begin nerr++; $display("FAIL full_calc_cnt got rdy=%b c=%0d ovf=%b want 1 4 0", op_ready, count, err_overflow); end
  endtask

  task automatic test_rst_mid();
    cyc(1'b0, 2'b01, 1'b0, 1'b1);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    nvec++; if (mem_rd_opb !== 1'b1) begin nerr++; $display("FAIL rst_mid_rdb got opb=%b want 1", mem_rd_opb); end
    cyc(1'b0, 2'b01, 1'b0, 1'b1);
    nvec++; if ({mem_wr_en, op_ready, count, head, tail} !== {1'b0, 1'b1, 4'd0, 3'd0, 3'd0}) begin nerr++; $display("FAIL rst_mid got wr=%b rdy=%b c=%0d h=%0d t=%0d want 0 1 0 0 0", mem_wr_en, op_ready, count, head, tail); end
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    nvec++; if (mem_wr_en !== 1'b0) begin nerr++; $display("FAIL rst_mid_late got wr=%b want 0", mem_wr_en); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b0, 2'b01, 1'b0, 1'b1);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    nvec++; if ({mem_wr_en, count} !== {1'b0, 4'd1}) begin nerr++; $display("FAIL b2b_rdb got wr=%b c=%0d want 0 1", mem_wr_en, count); end
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    nvec++; if ({mem_wr_en, mem_wr_addr, count} !== {1'b1, 3'd2, 4'd1}) begin nerr++; $display("FAIL b2b_wb got wr=%b a=%0d c=%0d want 1 2 1", mem_wr_en, mem_wr_addr, count); end
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    nvec++; if ({mem_wr_en, op_ready, count} !== {1'b0, 1'b1, 4'd1}) begin nerr++; $display("FAIL b2b_idle got wr=%b rdy=%b c=%0d want 0 1 1", mem_wr_en, op_ready, count); end
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    nvec++; if ({mem_wr_en, mem_wr_addr, count} !== {1'b1, 3'd3, 4'd2}) begin nerr++; $display("FAIL b2b_push got wr=%b a=%0d c=%0d want 1 3 2", mem_wr_en, mem_wr_addr, count); end
  endtask

  task automatic test_random();
    logic [17:0] got, exp;
    cyc(1'b0, 2'b01, 1'b0, 1'b1);
    for (int n = 0; n < 800; n++) begin
      cyc(1'($urandom_range(3) != 0), 2'($urandom), 1'($urandom_range(15) == 0), 1'($urandom_range(63) == 0));
      got = {op_ready, head, tail, count, full, empty, err_overflow, err_underflow, mem_rd_en, mem_rd_opb, mem_wr_en};
      exp = {m_busy == 0, 3'(m_head), 3'(m_tail), 4'(m_count), m_count == DEPTH, m_count == 0, m_ovf, m_unf, e_rd_en, e_rd_opb, e_wr_en};
      nvec++; if (got !== exp) begin nerr++; $display("FAIL rand_state[%0d] got %b want %b", n, got, exp); end
      if (e_rd_en) begin nvec++; if (mem_rd_addr !== 3'(e_rd_addr)) begin nerr++; $display("FAIL rand_rd_addr[%0d] got %0d want %0d", n, mem_rd_addr, e_rd_addr); end end
      if (e_wr_en) begin nvec++; if (mem_wr_addr !== 3'(e_wr_addr)) begin nerr++; $display("FAIL rand_wr_addr[%0d] got %0d want %0d", n, mem_wr_addr, e_wr_addr); end end
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_underflow();
    test_calc_wrap();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/queue_controller_param.md
Name: queue_controller_param

Overview:
Parametrised successor to the calculator queue controller. It manages a circular queue of DEPTH slots held in an external single-port-per-direction RAM, and decodes the same 2-bit opcode set: push, nop, calc, pop. Unlike a bare tail counter, it keeps independent head and tail pointers with wrap-around, full/empty flags and sticky error flags. It also sequences the calc operation (read two operands from the front, write the result at the back) through a small FSM with a ready/valid handshake. It sits between the instruction decoder and the operand RAM/ALU.

Parameters:
DEPTH, 8, number of queue slots; any value ≥ 2, need not be a power of two.
AW, 3, pointer/address width; must satisfy 2**AW ≥ DEPTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
op_valid  input  1  opcode presented this cycle.
opcode  input  2  00 push, 01 nop, 10 calc (pop two front, push result), 11 pop front.
op_ready  output  1  1 only in IDLE; operation accepted on an edge where op_valid && op_ready.
err_clr  input  1  clears both sticky error flags.
mem_wr_en  output  1  registered one-cycle write strobe.
mem_wr_addr  output  AW  write slot.
mem_rd_en  output  1  registered one-cycle read strobe.
mem_rd_addr  output  AW  read slot.
mem_rd_opb  output  1  qualifies mem_rd_en: 0 = operand A/pop data, 1 = operand B.
head  output  AW  front pointer.
tail  output  AW  next free slot.
count  output  AW+1  occupancy, 0..DEPTH.
full  output  1  count == DEPTH (combinational from count).
empty  output  1  count == 0 (combinational from count).
err_overflow  output  1  sticky; push attempted while full.
err_underflow  output  1  sticky; pop with count < 1, or calc with count < 2.

Behaviour:
- Reset: on any edge with rst=1 the block returns to IDLE, regardless of state. head, tail and count go to 0. All mem_* outputs go to 0. Both error flags go to 0. rst takes priority over err_clr, op_valid and an in-flight calc; the aborted calc causes no write.
- Default: mem_wr_en, mem_rd_en and mem_rd_opb are 0 on every edge unless set below, so each strobe is a single-cycle pulse.
- Wrap: pointer + 1 gives 0 when it reaches DEPTH. Pointer + 2 gives (p + 2 − DEPTH) when p ≥ DEPTH − 2.
- FSM states: IDLE, RD_A, RD_B, WB. Transitions: IDLE→RD_A on an accepted legal calc; RD_A→RD_B→WB→IDLE unconditionally, one edge each. op_valid is ignored outside IDLE.
- Push (00), accepted:
  - If !full: mem_wr_en←1, mem_wr_addr←tail, tail←tail+1, count←count+1.
  - If full: err_overflow←1, no other change.
- Pop (11), accepted:
  - If !empty: mem_rd_en←1, mem_rd_addr←head, mem_rd_opb←0, head←head+1, count←count−1.
  - If empty: err_underflow←1, no other change.
- Calc (10), accepted with count ≥ 2:
  - At the acceptance edge: latch a=head, b=head+1 (wrapped) and w=tail. Then head←head+2, tail←tail+1, count←count−1, and go to RD_A.
  - Entering RD_A: mem_rd_en=1, addr=a, opb=0.
  - Entering RD_B: mem_rd_en=1, addr=b, opb=1.
  - Entering WB: mem_wr_en=1, addr=w.
  - Calc is legal when full, because the net occupancy change is −1. w may equal a in that case; the read precedes the write.
- Calc with count < 2: err_underflow←1, stay in IDLE, no pointer change.
- Nop (01): no effect.
- Latency: push and pop strobes appear 1 cycle after acceptance. For calc, the read strobes appear at +1 and +2 and the write at +3; op_ready returns at +4.
- err_clr: clears both flags on that edge, unless an error is being set on the same edge (set wins).

Test Plan:
1. DEPTH=5: reset, then push ×5 → wr_addr 0,1,2,3,4; count=5, full=1. A 6th push → err_overflow=1; tail stays 0 and count stays 5.
2. From empty: pop → err_underflow=1, no rd strobe. After err_clr → flag 0. Push 1 then calc → err_underflow=1, count stays 1.
3. DEPTH=5, head=3, count=3: calc → reads addr 3 (opb=0) then 4 (opb=1), write to tail. head becomes 0, count 2, op_ready low for exactly 3 cycles.
4. DEPTH=5, head=4: calc → reads 4 then 0; head becomes 1, verifying the +2 wrap. Full queue calc → write address equals first read address, count 4.
5. Assert rst during RD_B → no WB write strobe; next cycle op_ready=1, count=0, head=tail=0.
6. op_valid held high with opcode=00 throughout a calc → no extra push during RD_A/RD_B/WB; exactly one push is accepted on return to IDLE.
